// File: rtl/ctr_pkg.sv
// Shared types and constants for the counter sequencing controller.
package ctr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ctr_state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : ctr_pkg

// File: rtl/clk_prescaler.sv
// Clock-enable prescaler: counts enabled cycles and flags the last cycle of
// each DIV-cycle period. The caller qualifies tick with its own enable.
module clk_prescaler #(
    parameter int DIV   = 1,
    parameter int PRE_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_r;

    // Terminal phase of the prescaler period.
    always_comb begin
        tick = (pre_r == PRE_MAX);
    end

    // Prescaler counter: clear wins, otherwise advance and roll over on tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r <= {PRE_W{1'b0}};
        end else if (clr) begin
            pre_r <= {PRE_W{1'b0}};
        end else if (en) begin
            if (tick) begin
                pre_r <= {PRE_W{1'b0}};
            end else begin
                pre_r <= pre_r + {{(PRE_W-1){1'b0}}, 1'b1};
            end
        end else begin
            pre_r <= pre_r;
        end
    end

endmodule : clk_prescaler

// File: rtl/counter_ctrl.sv
// Run/stop sequencing controller owning the count register, a prescaled
// step enable and registered step/wrap/done event pulses.
module counter_ctrl
    import ctr_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DIV   = 1,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    input  logic             dir,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             step,
    output logic             wrap,
    output logic             done
);

    ctr_state_t       state_r, state_nx_s;
    logic [WIDTH-1:0] count_r, count_nx_s;
    logic             dir_r, dir_nx_s;
    logic             oneshot_r, oneshot_nx_s;
    logic             busy_r, step_r, wrap_r, done_r;
    logic             step_nx_s, wrap_nx_s;
    logic             pre_clr_s, pre_en_s, tick_s;

    clk_prescaler #(
        .DIV   (DIV),
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr_s),
        .en   (pre_en_s),
        .tick (tick_s)
    );

    // Next-state, next-count and event pulse decode.
    always_comb begin
        state_nx_s   = state_r;
        count_nx_s   = count_r;
        dir_nx_s     = dir_r;
        oneshot_nx_s = oneshot_r;
        step_nx_s    = 1'b0;
        wrap_nx_s    = 1'b0;
        pre_clr_s    = 1'b0;
        pre_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    count_nx_s = load_val;
                end else begin
                    count_nx_s = count_r;
                end
                // stop beats a coincident start, keeping the block idle
                if (start && !stop) begin
                    dir_nx_s     = dir;
                    oneshot_nx_s = oneshot;
                    pre_clr_s    = 1'b1;
                    state_nx_s   = ST_RUN;
                end else begin
                    state_nx_s   = ST_IDLE;
                end
            end
            ST_RUN: begin
                // stop freezes both count and prescaler, even on a tick cycle
                if (stop) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    pre_en_s = 1'b1;
                    if (tick_s) begin
                        if (dir_r == DIR_UP) begin
                            if (count_r == term_val) begin
                                if (oneshot_r) begin
                                    state_nx_s = ST_DONE;
                                end else begin
                                    count_nx_s = {WIDTH{1'b0}};
                                    step_nx_s  = 1'b1;
                                    wrap_nx_s  = 1'b1;
                                end
                            end else begin
                                count_nx_s = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
                                step_nx_s  = 1'b1;
                            end
                        end else begin
                            if (count_r == {WIDTH{1'b0}}) begin
                                if (oneshot_r) begin
                                    state_nx_s = ST_DONE;
                                end else begin
                                    count_nx_s = term_val;
                                    step_nx_s  = 1'b1;
                                    wrap_nx_s  = 1'b1;
                                end
                            end else begin
                                count_nx_s = count_r - {{(WIDTH-1){1'b0}}, 1'b1};
                                step_nx_s  = 1'b1;
                            end
                        end
                    end else begin
                        count_nx_s = count_r;
                    end
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, count, latched run options and registered event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            count_r   <= {WIDTH{1'b0}};
            dir_r     <= 1'b0;
            oneshot_r <= 1'b0;
            busy_r    <= 1'b0;
            step_r    <= 1'b0;
            wrap_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            count_r   <= count_nx_s;
            dir_r     <= dir_nx_s;
            oneshot_r <= oneshot_nx_s;
            busy_r    <= (state_nx_s == ST_RUN);
            step_r    <= step_nx_s;
            wrap_r    <= wrap_nx_s;
            done_r    <= (state_nx_s == ST_DONE);
        end
    end

    assign count = count_r;
    assign busy  = busy_r;
    assign step  = step_r;
    assign wrap  = wrap_r;
    assign done  = done_r;

endmodule : counter_ctrl

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: one instance with DIV=1, one with DIV=3,
// both driven by the same host inputs.
module tb_counter_ctrl;

    logic       clk;
    logic       rst;
    logic       start, stop, load, dir, oneshot;
    logic [1:0] load_val, term_val;

    logic [1:0] count1, count3;
    logic       busy1, step1, wrap1, done1;
    logic       busy3, step3, wrap3, done3;

    int total;
    int bad;

    counter_ctrl #(.WIDTH(2), .DIV(1), .PRE_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .term_val(term_val), .dir(dir), .oneshot(oneshot),
        .count(count1), .busy(busy1), .step(step1), .wrap(wrap1), .done(done1)
    );

    counter_ctrl #(.WIDTH(2), .DIV(3), .PRE_W(8)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .load(load),
        .load_val(load_val), .term_val(term_val), .dir(dir), .oneshot(oneshot),
        .count(count3), .busy(busy3), .step(step3), .wrap(wrap3), .done(done3)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic [1:0] c, input logic b,
                        input logic s, input logic w, input logic d);
        check_val({tag, ".count"}, {30'd0, count1}, {30'd0, c});
        check_val({tag, ".busy"},  {31'd0, busy1},  {31'd0, b});
        check_val({tag, ".step"},  {31'd0, step1},  {31'd0, s});
        check_val({tag, ".wrap"},  {31'd0, wrap1},  {31'd0, w});
        check_val({tag, ".done"},  {31'd0, done1},  {31'd0, d});
    endtask

    task automatic chk3(input string tag, input logic [1:0] c, input logic b,
                        input logic s, input logic w, input logic d);
        check_val({tag, ".count"}, {30'd0, count3}, {30'd0, c});
        check_val({tag, ".busy"},  {31'd0, busy3},  {31'd0, b});
        check_val({tag, ".step"},  {31'd0, step3},  {31'd0, s});
        check_val({tag, ".wrap"},  {31'd0, wrap3},  {31'd0, w});
        check_val({tag, ".done"},  {31'd0, done3},  {31'd0, d});
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0;
        dir = 1'b0; oneshot = 1'b0; load_val = 2'd0; term_val = 2'd0;
        cyc();
        cyc();
        chk1("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk3("reset3", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Free-running up, term 2: 1,2,0(wrap),1
        rst = 1'b0; term_val = 2'd2; start = 1'b1;
        cyc();
        chk1("fr_enter", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        cyc(); chk1("fr_s1", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(); chk1("fr_s2", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(); chk1("fr_s3", 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(); chk1("fr_s4", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Load in RUN is ignored
        load = 1'b1; load_val = 2'd0; dir = 1'b1;
        cyc(); chk1("run_load", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        load = 1'b0; dir = 1'b0;

        // Reset mid-RUN at count 2 (a wrap would be due next)
        rst = 1'b1;
        cyc(); chk1("rst_run", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // stop coincident with tick at count 1
        term_val = 2'd3; start = 1'b1;
        cyc(); chk1("st_enter", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        cyc(); chk1("st_s1", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        cyc(); chk1("st_stop", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;
        cyc(); chk1("st_idle", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        // start+stop together in IDLE
        start = 1'b1; stop = 1'b1;
        cyc(); chk1("ss_idle", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0; stop = 1'b0;

        // load+start same cycle, term 3 up free-run: 2,3,0(wrap)
        load = 1'b1; load_val = 2'd2; start = 1'b1;
        cyc(); chk1("ls_enter", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        load = 1'b0; start = 1'b0;
        cyc(); chk1("ls_s1", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(); chk1("ls_wrap", 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        cyc(); chk1("ls_stop", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;

        // Oneshot down on the DIV=3 instance from preload 3
        rst = 1'b1;
        cyc();
        rst = 1'b0; load = 1'b1; load_val = 2'd3;
        cyc(); chk3("os_load", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; dir = 1'b1; oneshot = 1'b1; start = 1'b1;
        cyc(); chk3("os_enter", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b0; dir = 1'b0; oneshot = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cyc(); chk3("os_wait_a", 2'(4 - k), 1'b1, 1'b0, 1'b0, 1'b0);
            cyc(); chk3("os_wait_b", 2'(4 - k), 1'b1, 1'b0, 1'b0, 1'b0);
            cyc(); chk3("os_step", 2'(3 - k), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        cyc(); chk3("os_term_a", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(); chk3("os_term_b", 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        cyc(); chk3("os_done", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
        cyc(); chk3("os_idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(); chk3("os_hold", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_counter_ctrl
